// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the memory-port arbiter, its two requesters (fetch, data) and the
// single synchronous memory port.
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  // Handshake: a requester holds req (with stable address/data) until it sees a one-cycle ack;
  // ack means the access was issued to memory at that edge. Read data comes back later as a
  // one-cycle rvalid pulse with rdata, in issue order.
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          stall;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_rw;
  logic [DW-1:0] m_q;
  logic          dbg_last_was_data;
  logic          dbg_load_outstanding;

  modport slave (
    input  flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_q,
    output if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata, stall,
           m_addr, m_data, m_rw, dbg_last_was_data, dbg_load_outstanding
  );

  modport master (
    output flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_q,
    input  if_ack, if_rvalid, if_rdata, d_ack, d_rvalid, d_rdata, stall,
           m_addr, m_data, m_rw, dbg_last_was_data, dbg_load_outstanding
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data load/store, tracks
// in-flight reads with a tag shift register and routes m_q back to the issuing requester.
module mem_port_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  logic              gnt_data;
  logic              gnt_fetch;
  logic              last_was_data_q, last_was_data_d;
  // Tag shift: valid bit and source bit (1 = data, 0 = fetch); slot RD_LAT-1 is the one exiting.
  logic [RD_LAT-1:0] tag_v_q, tag_v_d;
  logic [RD_LAT-1:0] tag_s_q, tag_s_d;
  logic              exit_v;
  logic              exit_s;
  logic              load_outstanding;

  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic              m_rw_q, m_rw_d;
  logic              if_ack_q, d_ack_q;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;

  always_comb begin
    gnt_data         = 1'b0;
    gnt_fetch        = 1'b0;
    tag_v_d          = '0;
    tag_s_d          = '0;
    exit_v           = 1'b0;
    exit_s           = 1'b0;
    m_addr_d         = m_addr_q;
    m_data_d         = m_data_q;
    m_rw_d           = 1'b0;
    last_was_data_d  = last_was_data_q;
    if_rvalid_d      = 1'b0;
    d_rvalid_d       = 1'b0;
    if_rdata_d       = if_rdata_q;
    d_rdata_d        = d_rdata_q;

    // Data has priority, except that a waiting fetch never sees two data grants in a row.
    gnt_data  = bus.d_req & ~(last_was_data_q & bus.if_req);
    gnt_fetch = bus.if_req & ~gnt_data;

    if (gnt_data) begin
      m_addr_d        = bus.d_addr;
      m_data_d        = bus.d_wdata;
      m_rw_d          = bus.d_we;
      last_was_data_d = 1'b1;
    end else if (gnt_fetch) begin
      m_addr_d        = bus.if_addr;
      last_was_data_d = 1'b0;
    end

    // Stores occupy a slot in the shift but never return data.
    tag_v_d[0] = gnt_fetch | (gnt_data & ~bus.d_we);
    tag_s_d[0] = gnt_data;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_s_d[i] = tag_s_q[i-1];
    end

    // A taken branch kills every fetch still in flight, including the one issued this edge
    // and the one whose data is arriving right now.
    if (bus.flush) begin
      tag_v_d = tag_v_d & tag_s_d;
    end
    exit_s = tag_s_q[RD_LAT-1];
    exit_v = tag_v_q[RD_LAT-1] & ~(bus.flush & ~exit_s);

    if (exit_v && exit_s) begin
      d_rvalid_d = 1'b1;
      d_rdata_d  = bus.m_q;
    end else if (exit_v) begin
      if_rvalid_d = 1'b1;
      if_rdata_d  = bus.m_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_addr_q        <= '0;
      m_data_q        <= '0;
      m_rw_q          <= 1'b0;
      if_ack_q        <= 1'b0;
      d_ack_q         <= 1'b0;
      if_rvalid_q     <= 1'b0;
      d_rvalid_q      <= 1'b0;
      if_rdata_q      <= '0;
      d_rdata_q       <= '0;
      last_was_data_q <= 1'b0;
      tag_v_q         <= '0;
      tag_s_q         <= '0;
    end else begin
      m_addr_q        <= m_addr_d;
      m_data_q        <= m_data_d;
      m_rw_q          <= m_rw_d;
      if_ack_q        <= gnt_fetch;
      d_ack_q         <= gnt_data;
      if_rvalid_q     <= if_rvalid_d;
      d_rvalid_q      <= d_rvalid_d;
      if_rdata_q      <= if_rdata_d;
      d_rdata_q       <= d_rdata_d;
      last_was_data_q <= last_was_data_d;
      tag_v_q         <= tag_v_d;
      tag_s_q         <= tag_s_d;
    end
  end

  // A load holds the pipeline until its data has left the shift; a store only until accepted.
  assign load_outstanding = |(tag_v_q & tag_s_q);
  assign bus.stall        = (bus.d_req & ~d_ack_q) | load_outstanding;

  assign bus.m_addr               = m_addr_q;
  assign bus.m_data               = m_data_q;
  assign bus.m_rw                 = m_rw_q;
  assign bus.if_ack               = if_ack_q;
  assign bus.d_ack                = d_ack_q;
  assign bus.if_rvalid            = if_rvalid_q;
  assign bus.d_rvalid             = d_rvalid_q;
  assign bus.if_rdata             = if_rdata_q;
  assign bus.d_rdata              = d_rdata_q;
  assign bus.dbg_last_was_data    = last_was_data_q;
  assign bus.dbg_load_outstanding = load_outstanding;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a cycle monitor with return-data scoreboard.
module tb_mem_port_arbiter;
  localparam int AW     = 12;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  assign bus.m_q = mem[bus.m_addr];

  always @(posedge clock) begin
    if (bus.m_rw) mem[bus.m_addr] <= bus.m_data;
  end

  // ---------------- scoreboard state ----------------
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   if_rv_cnt = 0;
  int   d_rv_cnt = 0;
  exp_t exp_if_q[$];
  exp_t exp_d_q[$];
  logic lwd = 1'b0;
  logic [AW-1:0] exp_m_addr = '0;

  logic          s_rst = 1'b0;
  logic          s_if_req, s_d_req, s_d_we, s_flush;
  logic [AW-1:0] s_if_addr, s_d_addr;
  logic [DW-1:0] s_d_wdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clock) begin
    cyc       <= cyc + 1;
    s_rst     <= reset;
    s_if_req  <= bus.if_req;
    s_if_addr <= bus.if_addr;
    s_d_req   <= bus.d_req;
    s_d_we    <= bus.d_we;
    s_d_addr  <= bus.d_addr;
    s_d_wdata <= bus.d_wdata;
    s_flush   <= bus.flush;
  end

  // Per-cycle monitor: grant rule, issue registers, return data/latency and stall.
  always @(negedge clock) begin : monitor
    exp_t e;
    logic gd, gf, exp_stall;
    if (!reset || !s_rst) begin
      exp_if_q.delete();
      exp_d_q.delete();
      lwd        = 1'b0;
      exp_m_addr = '0;
      check_val("rst_if_ack",    32'(bus.if_ack),    32'd0);
      check_val("rst_d_ack",     32'(bus.d_ack),     32'd0);
      check_val("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      check_val("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
      check_val("rst_if_rdata",  32'(bus.if_rdata),  32'd0);
      check_val("rst_d_rdata",   32'(bus.d_rdata),   32'd0);
      check_val("rst_m_addr",    32'(bus.m_addr),    32'd0);
      check_val("rst_m_data",    32'(bus.m_data),    32'd0);
      check_val("rst_m_rw",      32'(bus.m_rw),      32'd0);
      check_val("rst_stall",     32'(bus.stall),     32'(bus.d_req));
    end else begin
      gd = s_d_req & ~(lwd & s_if_req);
      gf = s_if_req & ~gd;
      check_val("if_ack", 32'(bus.if_ack), 32'(gf));
      check_val("d_ack",  32'(bus.d_ack),  32'(gd));
      if (gd) begin
        exp_m_addr = s_d_addr;
        lwd        = 1'b1;
        check_val("m_data", 32'(bus.m_data), 32'(s_d_wdata));
        if (s_d_we) begin
          ref_mem[s_d_addr] = s_d_wdata;
        end else begin
          e.data = ref_mem[s_d_addr];
          e.due  = cyc + RD_LAT;
          exp_d_q.push_back(e);
        end
      end else if (gf) begin
        exp_m_addr = s_if_addr;
        lwd        = 1'b0;
        e.data     = ref_mem[s_if_addr];
        e.due      = cyc + RD_LAT;
        exp_if_q.push_back(e);
      end
      check_val("m_addr", 32'(bus.m_addr), 32'(exp_m_addr));
      check_val("m_rw",   32'(bus.m_rw),   32'(gd & s_d_we));
      // Everything still queued is in flight at this edge, so a flush kills all fetch returns.
      if (s_flush) exp_if_q.delete();

      if (exp_if_q.size() > 0 && exp_if_q[0].due == cyc) begin
        e = exp_if_q.pop_front();
        check_val("if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check_val("if_rdata",  32'(bus.if_rdata),  32'(e.data));
      end else if (bus.if_rvalid) begin
        check_val("if_rvalid_unexpected", 32'(bus.if_rvalid), 32'd0);
      end
      if (exp_d_q.size() > 0 && exp_d_q[0].due == cyc) begin
        e = exp_d_q.pop_front();
        check_val("d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check_val("d_rdata",  32'(bus.d_rdata),  32'(e.data));
      end else if (bus.d_rvalid) begin
        check_val("d_rvalid_unexpected", 32'(bus.d_rvalid), 32'd0);
      end
      exp_stall = (bus.d_req & ~gd) | (exp_d_q.size() != 0);
      check_val("stall", 32'(bus.stall), 32'(exp_stall));
    end
    if (bus.if_rvalid) if_rv_cnt++;
    if (bus.d_rvalid)  d_rv_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic data_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input string tag);
    int n = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    do begin
      tick();
      n++;
    end while (!bus.d_ack && n < 50);
    if (!bus.d_ack) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    bus.d_req = 1'b0;
  endtask

  task automatic fetch_run(input logic [AW-1:0] start, input int n, input string tag);
    int got = 0;
    int guard = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = start;
    while (got < n && guard < 4 * n + 20) begin
      tick();
      guard++;
      if (bus.if_ack) begin
        got++;
        bus.if_addr = bus.if_addr + 12'd1;
      end
    end
    bus.if_req = 1'b0;
    if (got != n) check_val({tag, "_timeout"}, 32'(got), 32'(n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r_if, r_d, code, prev, guard;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    mem[12'h040]     = 16'hBEEF;
    ref_mem[12'h040] = 16'hBEEF;
    reset       = 1'b0;
    bus.flush   = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // 1: reset during an accepted load drops its return
    data_op(1'b0, 12'h050, 16'h0, "t1_load");
    reset = 1'b0;
    r_d = d_rv_cnt;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    check_val("t1_no_d_rvalid", 32'(d_rv_cnt - r_d), 32'd0);
    r_if = if_rv_cnt;
    fetch_run(12'h005, 1, "t1_fetch");
    check_val("t1_m_addr", 32'(bus.m_addr), 32'h005);
    tick();
    check_val("t1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check_val("t1_if_rdata",  32'(bus.if_rdata),  32'h1005);
    repeat (2) tick();

    // 2: streaming fetch
    r_if = if_rv_cnt;
    fetch_run(12'h000, 16, "t2");
    repeat (3) tick();
    check_val("t2_rvalid_count", 32'(if_rv_cnt - r_if), 32'd16);
    check_val("t2_last_rdata",   32'(bus.if_rdata),     32'h100F);

    // 3: load colliding with fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h300;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 12'h040;
    tick();
    check_val("t3_d_first", 32'(bus.d_ack),  32'd1);
    check_val("t3_f_waits", 32'(bus.if_ack), 32'd0);
    check_val("t3_stall",   32'(bus.stall),  32'd1);
    bus.d_req = 1'b0;
    tick();
    check_val("t3_f_next",  32'(bus.if_ack),   32'd1);
    check_val("t3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check_val("t3_d_rdata", 32'(bus.d_rdata),  32'hBEEF);
    bus.if_req = 1'b0;
    repeat (3) tick();

    // 4: store then readback
    r_d = d_rv_cnt;
    data_op(1'b1, 12'h123, 16'hA5A5, "t4_store");
    check_val("t4_m_rw",   32'(bus.m_rw),   32'd1);
    check_val("t4_m_addr", 32'(bus.m_addr), 32'h123);
    check_val("t4_m_data", 32'(bus.m_data), 32'hA5A5);
    tick();
    check_val("t4_m_rw_low", 32'(bus.m_rw), 32'd0);
    check_val("t4_no_d_rvalid", 32'(d_rv_cnt - r_d), 32'd0);
    data_op(1'b0, 12'h123, 16'h0, "t4_load");
    tick();
    check_val("t4_rb_rvalid", 32'(bus.d_rvalid), 32'd1);
    check_val("t4_rb_rdata",  32'(bus.d_rdata),  32'hA5A5);
    repeat (2) tick();

    // 5: back-to-back loads against a waiting fetch alternate grants
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h400;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 12'($urandom_range(0, (1 << AW) - 1));
    prev = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      code = bus.d_ack ? 1 : (bus.if_ack ? 2 : 0);
      if (k > 0) check_val("t5_alternate", 32'(code), (prev == 1) ? 32'd2 : 32'd1);
      prev = code;
      if (bus.if_ack) bus.if_addr = bus.if_addr + 12'd1;
      if (bus.d_ack)  bus.d_addr  = 12'($urandom_range(0, (1 << AW) - 1));
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    repeat ($urandom_range(2, 4)) tick();

    // 6a: flush on the edge of the second of two fetch grants kills both returns
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h200;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!bus.if_ack && guard < 20);
    if (!bus.if_ack) check_val("t6a_timeout", 32'd0, 32'd1);
    r_if = if_rv_cnt;
    bus.if_addr = 12'h201;
    bus.flush   = 1'b1;
    tick();
    check_val("t6a_second_grant", 32'(bus.if_ack), 32'd1);
    bus.flush  = 1'b0;
    bus.if_req = 1'b0;
    repeat (3) tick();
    check_val("t6a_no_if_rvalid", 32'(if_rv_cnt - r_if), 32'd0);

    // 6b: a load issued before the flush still returns; the flushed fetch does not
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h210;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 12'h040;
    tick();
    check_val("t6b_d_ack", 32'(bus.d_ack), 32'd1);
    bus.d_req = 1'b0;
    bus.flush = 1'b1;
    r_if = if_rv_cnt;
    r_d  = d_rv_cnt;
    tick();
    check_val("t6b_f_grant",  32'(bus.if_ack),   32'd1);
    check_val("t6b_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check_val("t6b_d_rdata",  32'(bus.d_rdata),  32'hBEEF);
    bus.flush  = 1'b0;
    bus.if_req = 1'b0;
    repeat (3) tick();
    check_val("t6b_no_if_rvalid", 32'(if_rv_cnt - r_if), 32'd0);
    check_val("t6b_one_d_rvalid", 32'(d_rv_cnt - r_d),   32'd1);

    // ---------------- final report ----------------
    repeat (4) tick();
    check_val("drain_if_q", 32'(exp_if_q.size()), 32'd0);
    check_val("drain_d_q",  32'(exp_d_q.size()),  32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
